// File: rtl/rf_dump_reader_if.sv
// Output stream of the register-file dump reader: one {addr, data, last} word per valid/ready transfer.
interface rf_dump_reader_if #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32
);
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_addr;
  logic [DATA_W-1:0] out_data;
  logic              out_last;

  modport master (
    output out_valid,
    output out_addr,
    output out_data,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_addr,
    input  out_data,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/rf_dump_reader.sv
// Debug-side sweeper for RF read port 3: streams {addr, data} for a latched range [lo..hi]
// to the debug bridge, one register per CAPTURE/SEND pair.
module rf_dump_reader #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] lo_addr,
  input  logic [ADDR_W-1:0] hi_addr,
  output logic [ADDR_W-1:0] rf_raddr3,
  input  logic [DATA_W-1:0] rf_rdata3,
  rf_dump_reader_if.master  out_if,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    SEND    = 2'd2,
    FINISH  = 2'd3
  } state_e;

  state_e            state_q,     state_d;
  logic [ADDR_W-1:0] cur_addr_q,  cur_addr_d;
  logic [ADDR_W-1:0] lo_q,        lo_d;
  logic [ADDR_W-1:0] hi_q,        hi_d;
  logic              out_valid_q, out_valid_d;
  logic [ADDR_W-1:0] out_addr_q,  out_addr_d;
  logic [DATA_W-1:0] out_data_q,  out_data_d;
  logic              out_last_q,  out_last_d;
  logic              busy_q,      busy_d;
  logic              done_q,      done_d;

  // State and output register bank
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cur_addr_q  <= '0;
      lo_q        <= '0;
      hi_q        <= '0;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      lo_q        <= lo_d;
      hi_q        <= hi_d;
      out_valid_q <= out_valid_d;
      out_addr_q  <= out_addr_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Next-state and output-register updates
  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    lo_d        = lo_q;
    hi_d        = hi_q;
    out_valid_d = out_valid_q;
    out_addr_d  = out_addr_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          lo_d       = lo_addr;
          hi_d       = hi_addr;
          cur_addr_d = lo_addr;
          state_d    = (lo_addr > hi_addr) ? FINISH : CAPTURE;
        end
      end
      CAPTURE: begin
        out_data_d  = rf_rdata3;
        out_addr_d  = cur_addr_q;
        out_last_d  = (cur_addr_q == hi_q);
        out_valid_d = 1'b1;
        state_d     = SEND;
      end
      SEND: begin
        // Counter only advances below hi, so a sweep ending at the top register never wraps
        if (out_valid_q && out_if.out_ready) begin
          out_valid_d = 1'b0;
          if (out_last_q) begin
            state_d = FINISH;
          end else begin
            cur_addr_d = cur_addr_q + ADDR_W'(1);
            state_d    = CAPTURE;
          end
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Status flags are registered copies of the next state
    busy_d = (state_d != IDLE);
    done_d = (state_d == FINISH);
  end

  assign rf_raddr3        = cur_addr_q;
  assign out_if.out_valid = out_valid_q;
  assign out_if.out_addr  = out_addr_q;
  assign out_if.out_data  = out_data_q;
  assign out_if.out_last  = out_last_q;
  assign busy             = busy_q;
  assign done             = done_q;

endmodule

// File: tb/tb_rf_dump_reader.sv
// Directed bench for rf_dump_reader: behavioural RF model, output-word collector and
// hand-computed expectations for ranges, backpressure, ignored starts and reset.
module tb_rf_dump_reader;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] lo_addr = '0;
  logic [ADDR_W-1:0] hi_addr = '0;
  logic [ADDR_W-1:0] rf_raddr3;
  logic [DATA_W-1:0] rf_rdata3;
  logic              busy;
  logic              done;

  rf_dump_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  rf_dump_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .lo_addr   (lo_addr),
    .hi_addr   (hi_addr),
    .rf_raddr3 (rf_raddr3),
    .rf_rdata3 (rf_rdata3),
    .out_if    (bus),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Register file model: x0 hardwired to zero
  logic [DATA_W-1:0] rf [32];
  assign rf_rdata3 = (rf_raddr3 == '0) ? '0 : rf[rf_raddr3];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int start_cyc = 0;
  int first_v_cyc = -1;
  int done_cnt = 0;
  int done_cyc = 0;
  int valid_cnt = 0;
  logic [37:0] words [$];

  always @(posedge clk) cyc <= cyc + 1;

  // Collector sampled mid-cycle, away from the active edge
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.out_valid && bus.out_ready)
        words.push_back({bus.out_last, bus.out_addr, bus.out_data});
      if (bus.out_valid) begin
        valid_cnt++;
        if (first_v_cyc < 0) first_v_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [37:0] exp_word(input int a, input logic last);
    logic [31:0] d;
    d = (a == 0) ? 32'h0 : 32'h1000_0000 + 32'(a);
    return {last, 5'(a), d};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_sweep(input logic [4:0] lo, input logic [4:0] hi);
    lo_addr     = lo;
    hi_addr     = hi;
    start       = 1'b1;
    start_cyc   = cyc;
    first_v_cyc = -1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int d0;
    int n;
    d0 = done_cnt;
    n  = 0;
    while (done_cnt == d0 && n < budget) begin
      tick();
      n++;
    end
    check(tag, 64'(done_cnt - d0), 64'd1);
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!bus.out_valid && n < 20) begin
      tick();
      n++;
    end
    check(tag, 64'(bus.out_valid), 64'd1);
  endtask

  task automatic handshake_n(input int cnt);
    for (int w = 0; w < cnt; w++) begin
      wait_valid($sformatf("hs_valid%0d", w));
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_errors %0d", n_errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    int d0;
    int v0;
    bus.out_ready = 1'b0;
    rf[0] = '0;
    for (int i = 1; i < 32; i++) rf[i] = 32'h1000_0000 + 32'(i);

    // Reset state
    #12;
    check("rst_valid", 64'(bus.out_valid), 64'd0);
    check("rst_busy",  64'(busy), 64'd0);
    check("rst_done",  64'(done), 64'd0);
    check("rst_raddr", 64'(rf_raddr3), 64'd0);
    check("rst_word",  64'({bus.out_last, bus.out_addr, bus.out_data}), 64'd0);
    @(posedge clk);
    #3 rst = 1'b0;
    tick();

    // 1: full sweep 0..31, ready tied high
    words.delete();
    bus.out_ready = 1'b1;
    start_sweep(5'd0, 5'd31);
    check("t1_busy", 64'(busy), 64'd1);
    wait_done(100, "t1_done");
    check("t1_count", 64'(words.size()), 64'd32);
    for (int i = 0; i < 32; i++)
      check($sformatf("t1_w%0d", i), 64'(words[i]), 64'(exp_word(i, i == 31)));
    check("t1_first_valid", 64'(first_v_cyc - start_cyc), 64'd2);
    check("t1_done_lat", 64'(done_cyc - start_cyc), 64'd65);
    check("t1_idle", 64'(busy), 64'd0);

    // 2: single-register sweep, then empty sweep
    words.delete();
    start_sweep(5'd5, 5'd5);
    wait_done(20, "t2_one_done");
    check("t2_one_count", 64'(words.size()), 64'd1);
    check("t2_one_word", 64'(words[0]), 64'(exp_word(5, 1'b1)));
    v0 = valid_cnt;
    start_sweep(5'd9, 5'd3);
    check("t2_empty_done_now", 64'(done), 64'd1);
    check("t2_empty_busy", 64'(busy), 64'd1);
    wait_done(10, "t2_empty_done");
    check("t2_empty_lat", 64'(done_cyc - start_cyc), 64'd1);
    check("t2_empty_words", 64'(words.size()), 64'd1);
    check("t2_empty_valid", 64'(valid_cnt - v0), 64'd0);

    // 3: backpressure, each word held seven cycles
    words.delete();
    bus.out_ready = 1'b0;
    start_sweep(5'd2, 5'd4);
    for (int w = 0; w < 3; w++) begin
      wait_valid($sformatf("t3_valid%0d", w));
      for (int k = 0; k < 7; k++) begin
        check($sformatf("t3_hold%0d_%0d", w, k),
              64'({bus.out_valid, bus.out_last, bus.out_addr, bus.out_data}),
              64'({1'b1, exp_word(2 + w, w == 2)}));
        tick();
      end
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
    end
    wait_done(10, "t3_done");
    check("t3_count", 64'(words.size()), 64'd3);
    for (int w = 0; w < 3; w++)
      check($sformatf("t3_order%0d", w), 64'(words[w]), 64'(exp_word(2 + w, w == 2)));

    // 4: starts while busy and at the done cycle are ignored
    words.delete();
    bus.out_ready = 1'b1;
    start_sweep(5'd0, 5'd31);
    n0 = start_cyc;
    d0 = done_cnt;
    repeat (10) tick();
    lo_addr = 5'd20; hi_addr = 5'd25; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    lo_addr = 5'd1; hi_addr = 5'd1; start = 1'b1;
    tick();
    start = 1'b0;
    while (cyc < n0 + 65) tick();
    check("t4_at_done", 64'(done), 64'd1);
    lo_addr = 5'd7; hi_addr = 5'd7; start = 1'b1;
    tick();
    start = 1'b0;
    check("t4_done_start_busy", 64'(busy), 64'd0);
    repeat (4) tick();
    check("t4_idle_valid", 64'(bus.out_valid), 64'd0);
    check("t4_count", 64'(words.size()), 64'd32);
    check("t4_w20", 64'(words[20]), 64'(exp_word(20, 1'b0)));
    check("t4_w31", 64'(words[31]), 64'(exp_word(31, 1'b1)));
    check("t4_done_once", 64'(done_cnt - d0), 64'd1);
    start_sweep(5'd7, 5'd7);
    wait_done(20, "t4_new_done");
    check("t4_new_count", 64'(words.size()), 64'd33);
    check("t4_new_word", 64'(words[32]), 64'(exp_word(7, 1'b1)));

    // 5: core writes during the sweep
    words.delete();
    bus.out_ready = 1'b0;
    start_sweep(5'd0, 5'd31);
    handshake_n(3);
    wait_valid("t5_valid3");
    check("t5_at3", 64'(bus.out_addr), 64'd3);
    rf[10] = 32'hDEAD_BEEF;
    rf[2]  = 32'h2222_2222;
    repeat (3) tick();
    bus.out_ready = 1'b1;
    wait_done(100, "t5_done");
    check("t5_count", 64'(words.size()), 64'd32);
    check("t5_w2", 64'(words[2]), 64'(exp_word(2, 1'b0)));
    check("t5_w3", 64'(words[3]), 64'(exp_word(3, 1'b0)));
    check("t5_w10", 64'(words[10]), 64'({1'b0, 5'd10, 32'hDEAD_BEEF}));
    check("t5_w11", 64'(words[11]), 64'(exp_word(11, 1'b0)));
    rf[10] = 32'h1000_000A;
    rf[2]  = 32'h1000_0002;

    // 6: asynchronous reset mid-SEND
    words.delete();
    bus.out_ready = 1'b0;
    start_sweep(5'd0, 5'd31);
    handshake_n(4);
    wait_valid("t6_valid4");
    check("t6_pre_raddr", 64'(rf_raddr3), 64'd4);
    d0 = done_cnt;
    #2 rst = 1'b1;
    #1;
    check("t6_rst_valid", 64'(bus.out_valid), 64'd0);
    check("t6_rst_busy",  64'(busy), 64'd0);
    check("t6_rst_raddr", 64'(rf_raddr3), 64'd0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    tick();
    check("t6_no_done", 64'(done_cnt - d0), 64'd0);
    words.delete();
    bus.out_ready = 1'b1;
    start_sweep(5'd5, 5'd6);
    wait_done(20, "t6_after_done");
    check("t6_count", 64'(words.size()), 64'd2);
    check("t6_w5", 64'(words[0]), 64'(exp_word(5, 1'b0)));
    check("t6_w6", 64'(words[1]), 64'(exp_word(6, 1'b1)));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
